// File: rtl/delta_spike_encoder_mc.sv
// Multi-channel delta-modulation spike encoder: one channel per cycle updates its baseline and
// posts UP/DOWN spikes into per-channel pending slots drained by a registered round-robin arbiter.
module delta_spike_encoder_mc #(
    parameter int unsigned          N_CH      = 4,
    parameter int unsigned          DATA_W    = 16,
    parameter logic [DATA_W-1:0]    INIT_BASE = '0,
    localparam int unsigned         CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic                     clr_i,
    input  logic [DATA_W-1:0]        delta_i,
    input  logic [N_CH*DATA_W-1:0]   sample_i,
    input  logic                     sample_valid_i,
    output logic                     sample_ready_o,
    output logic                     evt_valid_o,
    input  logic                     evt_ready_i,
    output logic [CH_W-1:0]          evt_ch_o,
    output logic                     evt_pol_o,
    output logic                     ovf_o,
    output logic                     busy_o
);

    localparam logic [0:0]       StIdle  = 1'b0;
    localparam logic [0:0]       StProc  = 1'b1;
    localparam int unsigned      IDXW    = CH_W + 1;
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(N_CH - 1);

    logic [0:0]        state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [DATA_W-1:0] smp_q [N_CH];
    logic [DATA_W-1:0] smp_d [N_CH];
    logic [DATA_W-1:0] base_q [N_CH];
    logic [DATA_W-1:0] base_d [N_CH];
    logic [DATA_W-1:0] dlt_q, dlt_d;
    logic [N_CH-1:0]   init_q, init_d, pend_q, pend_d, pol_q, pol_d;
    logic              ovf_q, ovf_d;
    logic [CH_W-1:0]   rr_q, rr_d, och_q, och_d;
    logic              ov_q, ov_d, opol_q, opol_d;
    logic              run_q;

    logic [DATA_W-1:0] x, b;
    logic [DATA_W:0]   sum;
    logic              spike, spike_up, found;
    logic [IDXW-1:0]   idx_w;
    logic [CH_W-1:0]   idx;

    assign sample_ready_o = run_q & (state_q == StIdle) & en_i & ~clr_i;
    assign evt_valid_o    = ov_q;
    assign evt_ch_o       = och_q;
    assign evt_pol_o      = opol_q;
    assign ovf_o          = ovf_q;
    assign busy_o         = (state_q == StProc);

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        smp_d    = smp_q;
        dlt_d    = dlt_q;
        base_d   = base_q;
        init_d   = init_q;
        pend_d   = pend_q;
        pol_d    = pol_q;
        ovf_d    = ovf_q;
        rr_d     = rr_q;
        ov_d     = ov_q;
        och_d    = och_q;
        opol_d   = opol_q;
        x        = smp_q[ch_q];
        b        = base_q[ch_q];
        sum      = {1'b0, b} + {1'b0, dlt_q};
        spike    = 1'b0;
        spike_up = 1'b0;
        found    = 1'b0;
        idx_w    = '0;
        idx      = '0;

        // Retire the displayed event first so a same-cycle spike on that channel can refill it.
        if (ov_q && evt_ready_i) begin
            pend_d[och_q] = 1'b0;
            rr_d          = (och_q == LAST_CH) ? '0 : och_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (sample_valid_i && sample_ready_o) begin
                    for (int k = 0; k < N_CH; k++) begin
                        smp_d[k] = sample_i[k*DATA_W +: DATA_W];
                    end
                    dlt_d   = delta_i;
                    ch_d    = '0;
                    state_d = StProc;
                end
            end
            StProc: begin
                if (!init_q[ch_q]) begin
                    base_d[ch_q] = x;
                    init_d[ch_q] = 1'b1;
                end else if (dlt_q == '0) begin
                    base_d[ch_q] = x;
                end else if (!sum[DATA_W] && ({1'b0, x} >= sum)) begin
                    spike        = 1'b1;
                    spike_up     = 1'b1;
                    base_d[ch_q] = sum[DATA_W-1:0];
                end else if ((b >= dlt_q) && (x <= b - dlt_q)) begin
                    spike        = 1'b1;
                    base_d[ch_q] = b - dlt_q;
                end
                if (spike) begin
                    if (!pend_d[ch_q]) begin
                        pend_d[ch_q] = 1'b1;
                        pol_d[ch_q]  = spike_up;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if (ch_q == LAST_CH) begin
                    state_d = StIdle;
                end else begin
                    ch_d = ch_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Output register holds while stalled; otherwise pick next pending at/after rr.
        if (!(ov_q && !evt_ready_i)) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                idx_w = {1'b0, rr_d} + IDXW'(i);
                if (idx_w >= IDXW'(N_CH)) begin
                    idx_w = idx_w - IDXW'(N_CH);
                end
                idx = idx_w[CH_W-1:0];
                if (!found && pend_d[idx]) begin
                    found  = 1'b1;
                    och_d  = idx;
                    opol_d = pol_d[idx];
                end
            end
            ov_d = found;
        end

        if (clr_i) begin
            state_d = StIdle;
            pend_d  = '0;
            init_d  = '0;
            ovf_d   = 1'b0;
            ov_d    = 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                base_d[k] = INIT_BASE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            ch_q    <= '0;
            dlt_q   <= '0;
            init_q  <= '0;
            pend_q  <= '0;
            pol_q   <= '0;
            ovf_q   <= 1'b0;
            rr_q    <= '0;
            ov_q    <= 1'b0;
            och_q   <= '0;
            opol_q  <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                smp_q[k]  <= '0;
                base_q[k] <= INIT_BASE;
            end
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            dlt_q   <= dlt_d;
            init_q  <= init_d;
            pend_q  <= pend_d;
            pol_q   <= pol_d;
            ovf_q   <= ovf_d;
            rr_q    <= rr_d;
            ov_q    <= ov_d;
            och_q   <= och_d;
            opol_q  <= opol_d;
            smp_q   <= smp_d;
            base_q  <= base_d;
        end
    end

    // Keeps sample_ready_o low until the first edge after reset release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_delta_spike_encoder_mc.sv
// Directed bench for delta_spike_encoder_mc (N_CH=4, DATA_W=16, delta=10).
module tb_delta_spike_encoder_mc;

    localparam int unsigned N_CH   = 4;
    localparam int unsigned DATA_W = 16;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic                   en_i;
    logic                   clr_i;
    logic [DATA_W-1:0]      delta_i;
    logic [N_CH*DATA_W-1:0] sample_i;
    logic                   sample_valid_i;
    logic                   sample_ready_o;
    logic                   evt_valid_o;
    logic                   evt_ready_i;
    logic [1:0]             evt_ch_o;
    logic                   evt_pol_o;
    logic                   ovf_o;
    logic                   busy_o;

    int total = 0;
    int bad   = 0;
    int lat;
    int evq[$];

    delta_spike_encoder_mc #(
        .N_CH   (N_CH),
        .DATA_W (DATA_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .en_i           (en_i),
        .clr_i          (clr_i),
        .delta_i        (delta_i),
        .sample_i       (sample_i),
        .sample_valid_i (sample_valid_i),
        .sample_ready_o (sample_ready_o),
        .evt_valid_o    (evt_valid_o),
        .evt_ready_i    (evt_ready_i),
        .evt_ch_o       (evt_ch_o),
        .evt_pol_o      (evt_pol_o),
        .ovf_o          (ovf_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Events are logged as pol*4+ch when a handshake will occur at the coming edge.
    task automatic tick();
        if (evt_valid_o && evt_ready_i) evq.push_back(int'(evt_pol_o) * 4 + int'(evt_ch_o));
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input int c0, input int c1, input int c2, input int c3);
        int n;
        evq.delete();
        n = 0;
        while (!sample_ready_o && n < 100) begin
            tick();
            n++;
        end
        check("ready_before_send", 32'(sample_ready_o), 32'd1);
        sample_i       = {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
        sample_valid_i = 1'b1;
        tick();
        sample_valid_i = 1'b0;
        check("busy_in_proc", 32'(busy_o), 32'd1);
        lat = 1;
        while (!sample_ready_o && lat < 50) begin
            tick();
            lat++;
        end
        check("accept_to_ready", 32'(lat), 32'd5);
        repeat (3) tick();
    endtask

    initial begin
        rst_ni         = 1'b1;
        en_i           = 1'b1;
        clr_i          = 1'b0;
        delta_i        = 16'd10;
        sample_i       = '0;
        sample_valid_i = 1'b0;
        evt_ready_i    = 1'b1;
        #2 rst_ni = 1'b0;
        #2;
        check("rst_ready", 32'(sample_ready_o), 32'd0);
        check("rst_evt_valid", 32'(evt_valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_ovf", 32'(ovf_o), 32'd0);
        repeat (2) tick();
        rst_ni = 1'b1;
        tick();
        check("ready_after_rst", 32'(sample_ready_o), 32'd1);

        // First vector only initialises baselines.
        send(100, 200, 300, 400);
        check("init_no_events", 32'(evq.size()), 32'd0);

        send(115, 185, 305, 400);
        check("v2_count", 32'(evq.size()), 32'd2);
        if (evq.size() == 2) begin
            check("v2_ev0_ch0_up", 32'(evq[0]), 32'd4);
            check("v2_ev1_ch1_dn", 32'(evq[1]), 32'd1);
        end

        // Baselines now {110,190,300,400}: all four channels spike, held with ready low.
        evt_ready_i = 1'b0;
        send(120, 180, 320, 420);
        check("stall_valid", 32'(evt_valid_o), 32'd1);
        check("stall_ch", 32'(evt_ch_o), 32'd0);
        check("stall_pol", 32'(evt_pol_o), 32'd1);
        tick();
        check("stall_ch_stable", 32'(evt_ch_o), 32'd0);
        evt_ready_i = 1'b1;
        evq.delete();
        repeat (4) tick();
        check("drain_count", 32'(evq.size()), 32'd4);
        if (evq.size() == 4) begin
            check("drain_0", 32'(evq[0]), 32'd4);
            check("drain_1", 32'(evq[1]), 32'd1);
            check("drain_2", 32'(evq[2]), 32'd6);
            check("drain_3", 32'(evq[3]), 32'd7);
        end
        check("drain_empty", 32'(evt_valid_o), 32'd0);
        check("no_ovf_yet", 32'(ovf_o), 32'd0);

        // Baselines {120,180,310,410}: two ch0 UP spikes with the slot stalled.
        evt_ready_i = 1'b0;
        send(130, 180, 310, 410);
        check("ovf_first_pending", 32'(evt_valid_o), 32'd1);
        send(140, 180, 310, 410);
        check("ovf_set", 32'(ovf_o), 32'd1);
        evt_ready_i = 1'b1;
        evq.delete();
        repeat (3) tick();
        check("ovf_one_event", 32'(evq.size()), 32'd1);
        if (evq.size() == 1) check("ovf_event_ch0_up", 32'(evq[0]), 32'd4);
        check("ovf_sticky", 32'(ovf_o), 32'd1);

        evt_ready_i = 1'b0;
        send(150, 180, 310, 410);
        check("pre_clr_valid", 32'(evt_valid_o), 32'd1);
        clr_i = 1'b1;
        #1;
        check("clr_blocks_ready", 32'(sample_ready_o), 32'd0);
        tick();
        clr_i = 1'b0;
        check("clr_ovf", 32'(ovf_o), 32'd0);
        check("clr_evt_valid", 32'(evt_valid_o), 32'd0);
        check("clr_busy", 32'(busy_o), 32'd0);

        // Saturation at both ends after clr re-initialisation.
        evt_ready_i = 1'b1;
        send(65530, 5, 0, 0);
        check("sat_init_none", 32'(evq.size()), 32'd0);
        send(65535, 0, 0, 0);
        check("sat_no_events", 32'(evq.size()), 32'd0);
        send(65521, 15, 0, 0);
        check("sat_base_kept_count", 32'(evq.size()), 32'd1);
        if (evq.size() == 1) check("sat_base_kept_ev", 32'(evq[0]), 32'd5);

        // Async reset mid-vector, after the ch1 step.
        sample_i       = {16'd0, 16'd0, 16'd30, 16'd65500};
        sample_valid_i = 1'b1;
        tick();
        sample_valid_i = 1'b0;
        tick();
        tick();
        check("pre_rst_busy", 32'(busy_o), 32'd1);
        check("pre_rst_valid", 32'(evt_valid_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_valid", 32'(evt_valid_o), 32'd0);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_ready", 32'(sample_ready_o), 32'd0);
        check("mid_rst_ch", 32'(evt_ch_o), 32'd0);
        check("mid_rst_pol", 32'(evt_pol_o), 32'd0);
        check("mid_rst_ovf", 32'(ovf_o), 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        check("post_rst_ready", 32'(sample_ready_o), 32'd1);
        check("post_rst_valid", 32'(evt_valid_o), 32'd0);
        send(1000, 2000, 3000, 4000);
        check("reinit_no_events", 32'(evq.size()), 32'd0);
        send(1010, 2000, 3000, 4000);
        check("reinit_base_count", 32'(evq.size()), 32'd1);
        if (evq.size() == 1) check("reinit_base_ev", 32'(evq[0]), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/delta_spike_encoder_mc.md
Name: delta_spike_encoder_mc

Overview:
- Multi-channel, parametrised delta-modulation spike encoder; generalises the single-channel ECG threshold encoder.
- Accepts one sample vector per transfer via valid/ready and tracks a per-channel baseline.
- Emits signed (UP/DOWN) spike events through a round-robin arbitrated valid/ready event stream.
- Sits between the ADC/sample front end and the SNN input layer.

Parameters:
N_CH, 4, number of input channels (1..16)
DATA_W, 16, unsigned sample/threshold width
CH_W, $clog2(N_CH) (min 1), channel index width (derived, localparam)
INIT_BASE, 0, baseline value after reset / clr_i

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
en_i  in  1  encoder enable; when low, sample_ready_o=0, events still drain
clr_i  in  1  sync clear: baselines->INIT_BASE, pending flags, init flags and ovf_o cleared
delta_i  in  DATA_W  threshold step, shared by all channels, sampled at sample acceptance
sample_i  in  N_CH*DATA_W  packed samples, channel k at [k*DATA_W +: DATA_W]
sample_valid_i  in  1  sample vector valid
sample_ready_o  out  1  encoder can accept a vector
evt_valid_o  out  1  spike event valid
evt_ready_i  in  1  consumer accepts event
evt_ch_o  out  CH_W  channel of event
evt_pol_o  out  1  1=UP, 0=DOWN
ovf_o  out  1  sticky: a spike was dropped because that channel's pending slot was full
busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset (rst_ni=0, async): FSM=IDLE, baselines=INIT_BASE, per-channel init flags=0, pending=0, RR pointer=0. All outputs 0 during reset.
- FSM IDLE: sample_ready_o = en_i & ~clr_i. Handshake when sample_valid_i & sample_ready_o: latch sample vector and delta_i, ch_idx=0, go PROC.
- FSM PROC: one channel per cycle, ch_idx 0..N_CH-1. After channel N_CH-1 return to IDLE. Accept-to-ready latency = N_CH+1 cycles. busy_o=1 in PROC.
- Per-channel step, x=sample, b=baseline, d=latched delta; arithmetic in DATA_W+1 bits:
  - init flag 0: b<=x, init<=1, no spike.
  - d==0: b<=x, no spike.
  - x >= b+d, with b+d not overflowing 2^DATA_W: UP spike, b<=b+d.
  - x <= b-d, with b>=d: DOWN spike, b<=b-d.
  - Otherwise no change.
- At most one step per sample per channel; large jumps produce one spike per sample. Never wrap: the overflow/underflow cases simply produce no spike.
- Pending slot per channel (valid+polarity):
  - Spike with slot empty: set it.
  - Spike with slot full and not being consumed this cycle: drop new spike, set ovf_o.
  - Spike with slot full and being consumed this cycle: new spike occupies the slot.
- Event output: evt_valid_o=|pending. Round-robin arbiter selects the first pending channel at or after the RR pointer. evt_ch_o/evt_pol_o are stable while evt_valid_o & ~evt_ready_i.
- On handshake: clear that slot; RR pointer <= granted channel + 1, mod N_CH.
- Arbiter is registered-output. A newly set pending slot is visible on evt_valid_o the cycle after its PROC step.
- clr_i: takes effect next edge and overrides everything. FSM->IDLE; an in-flight vector is aborted and its remaining channels are discarded. Pending, ovf_o, init flags and baselines are cleared.
- en_i low mid-PROC: current vector completes; no new acceptance.
- Reset mid-operation: everything returns to reset state immediately; no event is emitted.

Test Plan:
- N_CH=4, DATA_W=16, d=10: first vector {100,200,300,400}. Result: no events; baselines=sample.
- Second vector ch0=115. Result: one UP event ch0, baseline0=110.
- Second vector ch1=185. Result: DOWN ch1, baseline1=190.
- Same vector with ch2=305. Result: ch2 gives no event.
- Vector {120,180,320,420} after init, with evt_ready_i held 0. Result: 4 pending slots. Then hold ready=1: events emerge ch0,ch1,ch2,ch3 in order with pol U,D,U,U; accept-to-ready latency = 5 cycles.
- Overflow: ch0 UP pending with ready=0, then another ch0 UP sample. Result: ovf_o=1, only one ch0 event. clr_i pulse: ovf_o=0, evt_valid_o=0.
- Saturation: baseline 65530, d=10, x=65535. Result: no event, baseline unchanged. Baseline 5, d=10, x=0. Result: no event.
- Async reset asserted in PROC after channel 1 step. Result: all outputs 0 immediately, sample_ready_o=1 one cycle after release with en_i=1; next vector re-initialises baselines.
